// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder: word-wide req/ack memory responder over a byte array.
// Optional wait states are enabled by defining MEM_WAIT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 3) begin : g_wait_range_err
    $error("mem_responder: WAIT_CYCLES must be 0..3");
  end

`ifdef MEM_WAIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
`endif

  state_t        state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [DEPTH_BYTES];

  logic [AW-1:0] txn_addr;
  logic          txn_wr;
  logic [31:0]   txn_wdata;
  logic [31:0]   mem_word;
  logic          enter_resp;
  logic          mem_we;
  logic          unused_addr;

`ifdef MEM_WAIT_EN
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    cnt_q, cnt_d;
`endif

  assign unused_addr = ^addr[31:AW];

  always_comb begin
    mem_word = {mem_q[{txn_addr[AW-1:2], 2'd3}], mem_q[{txn_addr[AW-1:2], 2'd2}],
                mem_q[{txn_addr[AW-1:2], 2'd1}], mem_q[{txn_addr[AW-1:2], 2'd0}]};
  end

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    txn_addr   = addr[AW-1:0];
    txn_wr     = wr;
    txn_wdata  = wdata;
`ifdef MEM_WAIT_EN
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    // Outside IDLE the transaction comes from the latched copy, not the live bus.
    if (state_q != S_IDLE) begin
      txn_addr  = addr_q;
      txn_wr    = wr_q;
      txn_wdata = wdata_q;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
`ifdef MEM_WAIT_EN
          addr_d  = addr[AW-1:0];
          wr_d    = wr;
          wdata_d = wdata;
          if (WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
            cnt_d   = 2'(WAIT_CYCLES - 1);
          end else begin
            enter_resp = 1'b1;
          end
`else
          enter_resp = 1'b1;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      S_WAIT: begin
        if (cnt_q == 2'd0) enter_resp = 1'b1;
        else               cnt_d = cnt_q - 2'd1;
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      state_d = S_RESP;
      ack_d   = 1'b1;
      err_d   = |txn_addr[1:0];
      if (!txn_wr && !err_d) rdata_d = mem_word;
    end

    mem_we = enter_resp && txn_wr && (txn_addr[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_WAIT_EN
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef MEM_WAIT_EN
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
`endif
    end
  end

  // Array contents survive reset; only the commit itself is gated by it.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[{txn_addr[AW-1:2], 2'd0}] <= txn_wdata[7:0];
      mem_q[{txn_addr[AW-1:2], 2'd1}] <= txn_wdata[15:8];
      mem_q[{txn_addr[AW-1:2], 2'd2}] <= txn_wdata[23:16];
      mem_q[{txn_addr[AW-1:2], 2'd3}] <= txn_wdata[31:24];
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder: scoreboard bench for mem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

`ifdef MEM_WAIT_EN
  localparam int WAIT = 2;
`else
  localparam int WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [7:0]  model_mem [256];
  logic [31:0] model_rdata = '0;
  logic [32:0] sb_q [$];

  mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, input bit tail, input string nm);
    logic [32:0] e;
    logic        ee;
    int          cyc;
    bit          b2b;
    b2b = (req == 1'b1);
    ee  = (a[1:0] != 2'b00);
    if (!ee) begin
      if (w) begin
        model_mem[a[7:0]]        = d[7:0];
        model_mem[a[7:0] + 8'd1] = d[15:8];
        model_mem[a[7:0] + 8'd2] = d[23:16];
        model_mem[a[7:0] + 8'd3] = d[31:24];
      end else begin
        model_rdata = {model_mem[a[7:0] + 8'd3], model_mem[a[7:0] + 8'd2],
                       model_mem[a[7:0] + 8'd1], model_mem[a[7:0]]};
      end
    end
    sb_q.push_back({model_rdata, ee});
    req = 1'b1; wr = w; addr = a; wdata = d;
    if (b2b) begin
      @(posedge clk); #1;
      tests++;
      if (ack !== 1'b0) begin
        fails++; $display("FAIL %s idle_gap: ack=%b want 0", nm, ack);
      end
    end
    @(posedge clk); #1;
    cyc = 1;
    while (ack !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (ack !== 1'b1 || cyc != 1 + WAIT) begin
      fails++; $display("FAIL %s latency: ack=%b after %0d cycles, want 1 after %0d", nm, ack, cyc, 1 + WAIT);
    end
    e = sb_q.pop_front();
    tests++;
    if (rdata !== e[32:1]) begin
      fails++; $display("FAIL %s rdata: got %h want %h", nm, rdata, e[32:1]);
    end
    tests++;
    if (err !== e[0]) begin
      fails++; $display("FAIL %s err: got %b want %b", nm, err, e[0]);
    end
    if (!keep) req = 1'b0;
    if (tail) begin
      @(posedge clk); #1;
      tests++;
      if (ack !== 1'b0 || err !== 1'b0) begin
        fails++; $display("FAIL %s pulse: ack=%b err=%b want 0 0", nm, ack, err);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      fails++; $display("FAIL reset_state: ack=%b err=%b rdata=%h want 0 0 0", ack, err, rdata);
    end
    reset = 1'b1; req = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      tests++;
      if (ack !== 1'b0) begin
        fails++; $display("FAIL reset_req_ignored: ack=%b want 0", ack);
      end
    end
  endtask

  task automatic test_basic();
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, "wr_10");
    do_txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, "rd_10");
  endtask

  task automatic test_misaligned();
    do_txn(1'b1, 32'h12, 32'h11223344, 1'b0, 1'b1, "wr_12_mis");
    do_txn(1'b0, 32'h13, 32'h0, 1'b0, 1'b1, "rd_13_mis");
    do_txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, "rd_10_after_mis");
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 32'h00, 32'h01020304, 1'b1, 1'b0, "b2b_wr_00");
    do_txn(1'b1, 32'h04, 32'h50607080, 1'b1, 1'b0, "b2b_wr_04");
    do_txn(1'b1, 32'h08, 32'h9ABCDEF0, 1'b0, 1'b1, "b2b_wr_08");
    do_txn(1'b0, 32'h00, 32'h0, 1'b1, 1'b0, "b2b_rd_00");
    do_txn(1'b0, 32'h04, 32'h0, 1'b1, 1'b0, "b2b_rd_04");
    do_txn(1'b0, 32'h08, 32'h0, 1'b0, 1'b1, "b2b_rd_08");
  endtask

  task automatic test_wrap();
    do_txn(1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 1'b1, "wr_104");
    do_txn(1'b0, 32'h04, 32'h0, 1'b0, 1'b1, "rd_04_alias");
    do_txn(1'b1, 32'hFC, 32'h0A0B0C0D, 1'b0, 1'b1, "wr_fc");
    do_txn(1'b0, 32'hFC, 32'h0, 1'b0, 1'b1, "rd_fc");
    do_txn(1'b0, 32'hFFFF_0100, 32'h0, 1'b0, 1'b1, "rd_100_alias");
  endtask

  task automatic test_reset_resp();
    do_txn(1'b1, 32'h30, 32'h13579BDF, 1'b0, 1'b0, "wr_30_rst");
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ack !== 1'b0 || rdata !== 32'h0) begin
      fails++; $display("FAIL reset_in_resp: ack=%b rdata=%h want 0 0", ack, rdata);
    end
    reset = 1'b1;
    model_rdata = '0;
    @(posedge clk); #1;
    do_txn(1'b0, 32'h30, 32'h0, 1'b0, 1'b1, "rd_30_after_rst");
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_reset_wait();
    int acks;
    do_txn(1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1, "wr_20_prior");
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ack !== 1'b0 || rdata !== 32'h0) begin
      fails++; $display("FAIL reset_in_wait: ack=%b rdata=%h want 0 0", ack, rdata);
    end
    reset = 1'b1;
    model_rdata = '0;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    tests++;
    if (acks != 0) begin
      fails++; $display("FAIL aborted_no_ack: got %0d acks want 0", acks);
    end
    do_txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, "rd_20_after_abort");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_back_to_back();
    test_wrap();
    test_reset_resp();
`ifdef MEM_WAIT_EN
    test_reset_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
